key_scan_multi: RTL

KEY_SCAN_MULTI -- requirements
Module: key_scan_multi

---
 rtl/key_scan_multi.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/key_scan_multi.sv
// Multi-channel key scanner: per-key synchronizer, debounce FSM, and long-press detection.
// Each channel reports a debounced level and one-cycle press, release and long-press pulses.
module key_scan_multi #(
  parameter int unsigned N_KEYS      = 4,
  parameter int unsigned DB_CYCLES   = 500000,
  parameter int unsigned LONG_CYCLES = 50000000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_KEYS-1:0] Pin_In,
  output logic [N_KEYS-1:0] Key_Level,
  output logic [N_KEYS-1:0] Press_Pulse,
  output logic [N_KEYS-1:0] Release_Pulse,
  output logic [N_KEYS-1:0] Long_Pulse
);

  localparam int unsigned DB_W    = $clog2(DB_CYCLES + 1);
  localparam int unsigned HOLD_W  = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;
  localparam bit          LONG_EN = (LONG_CYCLES != 0);
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DB_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
  localparam logic              PIN_IDLE = ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_e;

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] pressed_c;

  // Two-flop synchronizer; reset loads the released pin level so no phantom press appears.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= {N_KEYS{PIN_IDLE}};
      sync2_q <= {N_KEYS{PIN_IDLE}};
    end else begin
      sync1_q <= Pin_In;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_c = ACTIVE_LOW ? ~sync2_q : sync2_q;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    state_e            state_q, state_d;
    logic [DB_W-1:0]   db_q, db_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              rel_q, rel_d;
    logic              long_q, long_d;
    logic              p;

    assign p = pressed_c[i];

    always_ff @(posedge CLK) begin
      if (RST) begin
        state_q <= IDLE;
        db_q    <= '0;
        hold_q  <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        db_q    <= db_d;
        hold_q  <= hold_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        long_q  <= long_d;
      end
    end

    // Next state and counters; hold counter runs (saturating) through HELD and REL_DB.
    always_comb begin
      state_d = state_q;
      db_d    = db_q;
      hold_d  = hold_q;
      case (state_q)
        IDLE: begin
          if (p) begin
            state_d = PRESS_DB;
            db_d    = '0;
          end
        end
        PRESS_DB: begin
          if (!p) begin
            state_d = IDLE;
          end else if (db_q == DB_MAX) begin
            state_d = HELD;
            hold_d  = '0;
          end else begin
            db_d = db_q + DB_W'(1);
          end
        end
        HELD: begin
          if (hold_q != HOLD_MAX) hold_d = hold_q + HOLD_W'(1);
          if (!p) begin
            state_d = REL_DB;
            db_d    = '0;
          end
        end
        REL_DB: begin
          if (hold_q != HOLD_MAX) hold_d = hold_q + HOLD_W'(1);
          if (p) begin
            state_d = HELD;
          end else if (db_q == DB_MAX) begin
            state_d = IDLE;
          end else begin
            db_d = db_q + DB_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Output decode from the transition being taken; results land in the output registers.
    always_comb begin
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      long_d  = 1'b0;
      if (state_q == PRESS_DB && state_d == HELD) begin
        level_d = 1'b1;
        press_d = 1'b1;
      end
      if (state_q == REL_DB && state_d == IDLE) begin
        level_d = 1'b0;
        rel_d   = 1'b1;
      end
      if (LONG_EN && (state_q == HELD || state_q == REL_DB) && state_d != IDLE &&
          hold_q != HOLD_MAX && hold_d == HOLD_MAX) begin
        long_d = 1'b1;
      end
    end

    assign Key_Level[i]     = level_q;
    assign Press_Pulse[i]   = press_q;
    assign Release_Pulse[i] = rel_q;
    assign Long_Pulse[i]    = long_q;
  end

endmodule
